// File: rtl/wb_regfile_pkg.sv
// Shared RV32 definitions: widths, opcodes and load funct3 codes, plus the
// load-extension helper used by the writeback stage.
package wb_regfile_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OP_BUBBLE = 7'b0000000;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  // Pick the addressed byte/half out of a word-aligned read and extend it.
  // Unknown widths pass the whole word through.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [1:0]      lane,
                                                  input logic [2:0]      funct3);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [XLEN-1:0] res;
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (load_f3_e'(funct3))
      F3_LB:   res = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  res = {24'd0, byte_sel};
      F3_LH:   res = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  res = {16'd0, half_sel};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_regfile_rv_regfile.sv
// 32x32 integer register file: x0 hardwired to zero, one write port and two
// combinational read ports that see a same-cycle write.
module rv_regfile
  import wb_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2
);

  logic [XLEN-1:0] regs [NREGS];

  // Storage: cleared by reset, written on the edge unless targeting x0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read port 1 with write-through bypass.
  always_comb begin
    rdata1 = '0;
    if (raddr1 != '0) rdata1 = (we && (raddr1 == waddr)) ? wdata : regs[raddr1];
  end

  // Read port 2 with write-through bypass.
  always_comb begin
    rdata2 = '0;
    if (raddr2 != '0) rdata2 = (we && (raddr2 == waddr)) ? wdata : regs[raddr2];
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the value to commit from the MEM/WB register,
// writes it into the register file, exports it for forwarding and counts
// retired instructions.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] G_in,
  input  logic [31:0] Data_out_in,
  input  logic        MD_in,
  input  logic        RW_in,
  input  logic [4:0]  RD_in,
  input  logic [6:0]  opcode_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] IMM_in,
  input  logic [31:0] PC_in,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [63:0] instret
);

  logic [63:0] instret_q;

  // Writeback value selection; first matching opcode wins, ALU result otherwise.
  always_comb begin
    wb_data = G_in;
    case (opcode_in)
      OP_LUI:          wb_data = IMM_in;
      OP_AUIPC:        wb_data = PC_in + IMM_in;
      OP_JAL, OP_JALR: wb_data = PC_in + 32'd4;
      OP_LOAD:         if (MD_in) wb_data = load_extend(Data_out_in, G_in[1:0], funct3_in);
      default:         ;
    endcase
  end

  // Writes to x0 still show on wb_data but are never flagged for commit/forwarding.
  always_comb begin
    wb_en = RW_in & (RD_in != 5'd0);
    wb_rd = RD_in;
  end

  // Retired-instruction counter; bubbles (opcode 0) do not count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         instret_q <= '0;
    else if (opcode_in != OP_BUBBLE)   instret_q <= instret_q + 64'd1;
  end

  assign instret = instret_q;

  rv_regfile u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_en),
    .waddr  (RD_in),
    .wdata  (wb_data),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vectors with literal expectations plus a
// per-cycle comparison against a behavioural model of the writeback stage.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic [31:0] G_in, Data_out_in, IMM_in, PC_in;
  logic        MD_in, RW_in;
  logic [4:0]  RD_in, rs1_addr, rs2_addr;
  logic [6:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;
  logic mon_on = 1'b0;

  logic [31:0] m_regs [32];
  logic [63:0] m_instret;
  logic        preload_model = 1'b0;

  wb_regfile dut (
    .clk(clk), .reset(reset), .G_in(G_in), .Data_out_in(Data_out_in),
    .MD_in(MD_in), .RW_in(RW_in), .RD_in(RD_in), .opcode_in(opcode_in),
    .funct3_in(funct3_in), .IMM_in(IMM_in), .PC_in(PC_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Writeback value as the instruction set defines it.
  function automatic logic [31:0] exp_wb(input logic [6:0] op, input logic md,
                                         input logic [2:0] f3, input logic [31:0] g,
                                         input logic [31:0] d, input logic [31:0] imm,
                                         input logic [31:0] pc);
    logic [31:0] b_sh, h_sh;
    b_sh = d >> {g[1:0], 3'b000};
    h_sh = g[1] ? (d >> 16) : d;
    if (op == 7'h37) return imm;
    if (op == 7'h17) return pc + imm;
    if (op == 7'h6F || op == 7'h67) return pc + 32'd4;
    if (op == 7'h03 && md) begin
      case (f3)
        3'd0:    return {{24{b_sh[7]}}, b_sh[7:0]};
        3'd4:    return {24'd0, b_sh[7:0]};
        3'd1:    return {{16{h_sh[15]}}, h_sh[15:0]};
        3'd5:    return {16'd0, h_sh[15:0]};
        default: return d;
      endcase
    end
    return g;
  endfunction

  // Model state: architectural registers and retire count.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      m_instret <= 64'd0;
    end else begin
      if (RW_in && RD_in != 5'd0)
        m_regs[RD_in] <= exp_wb(opcode_in, MD_in, funct3_in, G_in, Data_out_in, IMM_in, PC_in);
      if (opcode_in != 7'd0)
        m_instret <= (preload_model ? 64'hFFFF_FFFF_FFFF_FFFF : m_instret) + 64'd1;
      else if (preload_model)
        m_instret <= 64'hFFFF_FFFF_FFFF_FFFF;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (mon_on) begin
      logic [31:0] e;
      logic        en;
      logic [31:0] r1, r2;
      e  = exp_wb(opcode_in, MD_in, funct3_in, G_in, Data_out_in, IMM_in, PC_in);
      en = RW_in && (RD_in != 5'd0);
      r1 = (rs1_addr == 5'd0) ? 32'd0 : (en && rs1_addr == RD_in) ? e : m_regs[rs1_addr];
      r2 = (rs2_addr == 5'd0) ? 32'd0 : (en && rs2_addr == RD_in) ? e : m_regs[rs2_addr];
      chk("mon_wb_data", {32'd0, wb_data}, {32'd0, e});
      chk("mon_wb_en", {63'd0, wb_en}, {63'd0, en});
      chk("mon_wb_rd", {59'd0, wb_rd}, {59'd0, RD_in});
      chk("mon_rs1", {32'd0, rs1_data}, {32'd0, r1});
      chk("mon_rs2", {32'd0, rs2_data}, {32'd0, r2});
      chk("mon_instret", instret, m_instret);
    end
  end

  // Present one MEM/WB bundle just after a rising edge, return at negedge+2.
  task automatic present(input logic [6:0] op, input logic rw, input logic [4:0] rd,
                         input logic md, input logic [2:0] f3, input logic [31:0] g,
                         input logic [31:0] dout, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    #1;
    preload_model = 1'b0;
    opcode_in = op; RW_in = rw; RD_in = rd; MD_in = md; funct3_in = f3;
    G_in = g; Data_out_in = dout; IMM_in = imm; PC_in = pc;
    rs1_addr = a1; rs2_addr = a2;
    @(negedge clk);
    #2;
  endtask

  task automatic bubble(input logic [4:0] a1, input logic [4:0] a2);
    present(7'd0, 1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, a1, a2);
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] g);
    present(7'h03, 1'b1, 5'd9, 1'b1, f3, g, 32'h80FF7F01, 32'd0, 32'd0, 5'd0, 5'd0);
  endtask

  initial begin
    reset = 1'b0;
    opcode_in = 7'd0; RW_in = 1'b0; RD_in = 5'd0; MD_in = 1'b0; funct3_in = 3'd0;
    G_in = 32'd0; Data_out_in = 32'd0; IMM_in = 32'd0; PC_in = 32'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1 reset = 1'b1;
    #1 mon_on = 1'b1;
    @(negedge clk); #2;
    chk("rst_wb_en", {63'd0, wb_en}, 64'd0);
    chk("rst_wb_data", {32'd0, wb_data}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 1; i < 32; i++) begin
      bubble(5'(i), 5'(32 - i));
      chk("rst_reg", {32'd0, rs1_data}, 64'd0);
    end
    chk("rst_instret_idle", instret, 64'd0);

    // 3 instructions, 2 bubbles, 1 instruction
    for (int i = 0; i < 3; i++)
      present(7'h13, 1'b0, 5'd0, 1'b0, 3'd0, 32'd1, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    bubble(5'd0, 5'd0);
    bubble(5'd0, 5'd0);
    present(7'h13, 1'b0, 5'd0, 1'b0, 3'd0, 32'd1, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    bubble(5'd0, 5'd0);
    chk("instret_4", instret, 64'd4);

    // LUI with same-cycle bypass, then stored read
    present(7'h37, 1'b1, 5'd5, 1'b0, 3'd0, 32'd0, 32'd0, 32'h12345000, 32'd0, 5'd0, 5'd5);
    chk("lui_wb_data", {32'd0, wb_data}, 64'h12345000);
    chk("lui_bypass", {32'd0, rs2_data}, 64'h12345000);
    bubble(5'd5, 5'd0);
    chk("lui_stored", {32'd0, rs1_data}, 64'h12345000);

    // Loads from 0x80FF7F01
    load(3'b000, 32'h1002);
    chk("lb", {32'd0, wb_data}, 64'hFFFFFFFF);
    load(3'b100, 32'h1003);
    chk("lbu", {32'd0, wb_data}, 64'h00000080);
    load(3'b001, 32'h1000);
    chk("lh", {32'd0, wb_data}, 64'h00007F01);
    load(3'b101, 32'h1002);
    chk("lhu", {32'd0, wb_data}, 64'h000080FF);
    load(3'b001, 32'h1003);
    chk("lh_odd", {32'd0, wb_data}, 64'hFFFF80FF);
    load(3'b010, 32'h1000);
    chk("lw", {32'd0, wb_data}, 64'h80FF7F01);
    load(3'b011, 32'h1001);
    chk("lw_other_f3", {32'd0, wb_data}, 64'h80FF7F01);
    present(7'h03, 1'b1, 5'd9, 1'b0, 3'd0, 32'h1234, 32'h80FF7F01, 32'd0, 32'd0, 5'd9, 5'd0);
    chk("load_md0", {32'd0, wb_data}, 64'h00001234);

    // Links and AUIPC
    present(7'h6F, 1'b1, 5'd1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h40, 32'h100, 5'd1, 5'd9);
    chk("jal", {32'd0, wb_data}, 64'h104);
    present(7'h67, 1'b1, 5'd2, 1'b0, 3'd0, 32'h55, 32'd0, 32'd0, 32'hFFFFFFFC, 5'd1, 5'd2);
    chk("jalr_wrap", {32'd0, wb_data}, 64'h0);
    chk("jal_stored", {32'd0, rs1_data}, 64'h104);
    present(7'h17, 1'b1, 5'd3, 1'b0, 3'd0, 32'd0, 32'd0, 32'h20, 32'hFFFFFFF0, 5'd3, 5'd0);
    chk("auipc_wrap", {32'd0, wb_data}, 64'h10);

    // x0 write
    present(7'h33, 1'b1, 5'd0, 1'b0, 3'd0, 32'hDEAD, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    chk("x0_wb_en", {63'd0, wb_en}, 64'd0);
    chk("x0_wb_data", {32'd0, wb_data}, 64'hDEAD);
    chk("x0_read", {32'd0, rs1_data}, 64'd0);
    bubble(5'd0, 5'd3);
    chk("x0_after", {32'd0, rs1_data}, 64'd0);

    // Counter wrap from all-ones
    present(7'h13, 1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    #1;
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    preload_model = 1'b1;
    bubble(5'd0, 5'd0);
    chk("instret_wrap", instret, 64'd0);

    // Reset in the middle of operation
    present(7'h37, 1'b1, 5'd7, 1'b0, 3'd0, 32'd0, 32'd0, 32'hABC00000, 32'd0, 5'd0, 5'd0);
    bubble(5'd7, 5'd5);
    chk("pre_rst_x7", {32'd0, rs1_data}, 64'hABC00000);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_x7", {32'd0, rs1_data}, 64'd0);
    chk("mid_rst_x5", {32'd0, rs2_data}, 64'd0);
    chk("mid_rst_instret", instret, 64'd0);
    // write presented while reset is held must be discarded
    present(7'h37, 1'b1, 5'd8, 1'b0, 3'd0, 32'd0, 32'd0, 32'h0F0F0000, 32'd0, 5'd0, 5'd0);
    chk("rst_wb_bypass_data", {32'd0, wb_data}, 64'h0F0F0000);
    bubble(5'd8, 5'd0);
    chk("rst_no_write", {32'd0, rs1_data}, 64'd0);
    chk("rst_no_count", instret, 64'd0);
    reset = 1'b0;
    bubble(5'd8, 5'd7);
    chk("post_rst_x8", {32'd0, rs1_data}, 64'd0);

    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and integer register file for the five-stage RV32I pipeline. Consumes the MEM/WB pipeline-register outputs and selects the writeback value: ALU result, extended load data, immediate, PC+IMM or link address. Commits that value to a 32×32 register file and serves the decode stage's two read ports with same-cycle write bypass. Also exports the writeback bus for EX-stage forwarding and keeps a 64-bit retired-instruction counter.

## Interface
- No parameters. XLEN is fixed at 32 and the register count at 32.
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- G_in  in  32  ALU result from MEM/WB; for loads, the effective address
- Data_out_in  in  32  raw data-memory read word, word-aligned
- MD_in  in  1  1 = result comes from memory (load)
- RW_in  in  1  register write enable
- RD_in  in  5  destination register
- opcode_in  in  7  instruction opcode
- funct3_in  in  3  load width/sign select
- IMM_in  in  32  decoded immediate
- PC_in  in  32  instruction PC
- rs1_addr, rs2_addr  in  5 each  decode-stage read addresses
- rs1_data, rs2_data  out  32 each  read data, bypassed
- wb_en  out  1  writeback will commit this cycle (RW_in & RD_in≠0)
- wb_rd  out  5  equals RD_in
- wb_data  out  32  selected writeback value, for forwarding
- instret  out  64  count of retired instructions

## Operation
- wb_data is selected by opcode_in. The first match wins:
  - 0110111 (LUI) → IMM_in
  - 0010111 (AUIPC) → PC_in+IMM_in
  - 1101111 or 1100111 (JAL/JALR) → PC_in+4
  - 0000011 with MD_in=1 → load-extended data (below)
  - otherwise → G_in
  - All additions are modulo 2^32 with no overflow flag.
- Load extension:
  - Byte lane = G_in[1:0]; halfword lane = G_in[1]. G_in[0] is ignored for halfwords.
  - funct3 000 LB sign-extends the byte; 100 LBU zero-extends it.
  - 001 LH sign-extends the half; 101 LHU zero-extends it.
  - 010 LW passes the word through.
  - Any other funct3 passes the word through.
- Register file:
  - x0 reads 0 always and is never written.
  - A write occurs on the rising edge when wb_en=1.
- Read ports are combinational. If rsN_addr equals RD_in, wb_en=1 and rsN_addr≠0, rsN_data = wb_data (write-through bypass). Otherwise rsN_data is the stored value.
- Bubble: opcode_in=0000000 with RW_in=0. This is the MEM/WB reset/flush value.
- instret increments by 1 on each edge where opcode_in≠0. It wraps from 2^64−1 to 0.

## Timing
- wb_data, wb_en, wb_rd and rs*_data are combinational: zero latency from inputs.
- The register update is visible in the stored array one edge after the instruction is presented. Through the bypass it is visible in the same cycle.
- instret reflects an instruction one edge after it is presented.
- While reset=1:
  - All 31 writable registers and instret are held at 0.
  - No write or increment occurs, even when wb_en=1.
  - The combinational outputs still follow their inputs. With a held MEM/WB bubble, wb_en=0 and wb_data=0.
- Reset asserted mid-operation discards any write in flight on that edge.
- A read and a write to the same register in the same cycle always return the new value.
- Writes to x0 still drive wb_data. wb_en stays 0, so forwarding ignores them.

## Structure
- Opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD) and funct3 load codes belong in the shared rv32 package, alongside the decoder's.
- One sub-module, rv_regfile: 32×32 array, async reset clear, one write port, two bypassed read ports.
- Writeback mux, load extension and instret counter live in wb_regfile.

## Test plan
- Reset, then read x1..x31 → all 0, instret=0. Raise reset mid-run after writes → all registers 0 immediately.
- LUI-class writes:
  - opcode 0110111, RD=5, IMM=0x12345000, RW=1 → wb_data=0x12345000.
  - On the next cycle, rs1_addr=5 → 0x12345000.
  - Same-cycle rs2_addr=5 → bypassed 0x12345000.
- Loads with Data_out=0x80FF7F01:
  - LB, G[1:0]=2 → 0xFFFFFFFF
  - LBU, G[1:0]=3 → 0x00000080
  - LH, G[1]=0 → 0x00007F01
  - LHU, G[1]=1 → 0x000080FF
  - LW → 0x80FF7F01
- Links and AUIPC:
  - JAL at PC=0x100 → wb_data=0x104.
  - AUIPC at PC=0xFFFFFFF0 with IMM=0x20 → 0x00000010 (wrap).
- x0 write: RW=1, RD=0, G=0xDEAD → wb_en=0, x0 still reads 0, rs1_addr=0 returns 0.
- Counter:
  - Present 3 instructions, 2 bubbles, 1 instruction → instret=4.
  - Preload-by-force 0xFFFFFFFFFFFFFFFF plus one instruction → 0.
